// File: rtl/trace_uart_streamer.sv
// Captures register-file writebacks from the trace port into a small FIFO and
// streams each one as a 10-byte 8N1 UART record: A5, pc[31:0], {3'b0,wnum}, wdata[31:0].
module trace_uart_streamer #(
    parameter int FIFO_DEPTH   = 16,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        open_trace,
    input  logic [31:0] debug_wb_pc,
    input  logic [3:0]  debug_wb_rf_wen,
    input  logic [4:0]  debug_wb_rf_wnum,
    input  logic [31:0] debug_wb_rf_wdata,
    output logic        uart_tx,
    output logic        fifo_full,
    output logic [15:0] drop_cnt,
    output logic        busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   DEPTH_C  = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [68:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full_q, full_d;
    logic [15:0]   drop_q, drop_d;
    logic [68:0]   rec_q, rec_d;
    logic [3:0]    byte_idx_q, byte_idx_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          event_s, push_s, pop_s, bit_end_s;
    logic [7:0]    cur_byte_s;

    // Record layout in the FIFO entry: pc = [68:37], wnum = [36:32], wdata = [31:0].
    function automatic logic [7:0] byte_sel(input logic [68:0] rec, input logic [3:0] idx);
        case (idx)
            4'd0:    byte_sel = 8'hA5;
            4'd1:    byte_sel = rec[68:61];
            4'd2:    byte_sel = rec[60:53];
            4'd3:    byte_sel = rec[52:45];
            4'd4:    byte_sel = rec[44:37];
            4'd5:    byte_sel = {3'b000, rec[36:32]};
            4'd6:    byte_sel = rec[31:24];
            4'd7:    byte_sel = rec[23:16];
            4'd8:    byte_sel = rec[15:8];
            4'd9:    byte_sel = rec[7:0];
            default: byte_sel = 8'hFF;
        endcase
    endfunction

    // FIFO bookkeeping; fullness is the registered value, so a same-cycle pop never admits a push.
    always_comb begin
        event_s  = open_trace && (debug_wb_rf_wen != 4'd0) && (debug_wb_rf_wnum != 5'd0);
        push_s   = event_s && !full_q;
        pop_s    = (state_q == IDLE) && (count_q != '0);
        wr_ptr_d = push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_s  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        full_d = (count_d == DEPTH_C);
        if (event_s && full_q && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end else begin
            drop_d = drop_q;
        end
    end

    // Serializer next-state; uart_tx and busy are computed one cycle ahead and registered.
    always_comb begin
        state_d    = state_q;
        rec_d      = rec_q;
        byte_idx_d = byte_idx_q;
        bit_idx_d  = bit_idx_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        cur_byte_s = byte_sel(rec_q, byte_idx_q);
        bit_end_s  = (cnt_q == BIT_LAST);
        if (state_q == IDLE || bit_end_s) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        case (state_q)
            IDLE: begin
                if (pop_s) begin
                    rec_d      = mem_q[rd_ptr_q];
                    byte_idx_d = 4'd0;
                    state_d    = START;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                end else begin
                    tx_d = 1'b1;
                end
            end
            START: begin
                if (bit_end_s) begin
                    state_d   = DATA;
                    bit_idx_d = 3'd0;
                    tx_d      = cur_byte_s[0];
                end else begin
                    tx_d = 1'b0;
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = cur_byte_s[bit_idx_q + 3'd1];
                    end
                end else begin
                    tx_d = cur_byte_s[bit_idx_q];
                end
            end
            STOP: begin
                if (bit_end_s) begin
                    if (byte_idx_q < 4'd9) begin
                        byte_idx_d = byte_idx_q + 4'd1;
                        state_d    = START;
                        tx_d       = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                    end
                end else begin
                    tx_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            drop_q     <= 16'd0;
            rec_q      <= '0;
            byte_idx_q <= 4'd0;
            bit_idx_q  <= 3'd0;
            cnt_q      <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            drop_q     <= drop_d;
            rec_q      <= rec_d;
            byte_idx_q <= byte_idx_d;
            bit_idx_q  <= bit_idx_d;
            cnt_q      <= cnt_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

    // FIFO storage; contents are unreset, pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push_s && !reset) begin
            mem_q[wr_ptr_q] <= {debug_wb_pc, debug_wb_rf_wnum, debug_wb_rf_wdata};
        end
    end

    assign uart_tx   = tx_q;
    assign fifo_full = full_q;
    assign drop_cnt  = drop_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_trace_uart_streamer.sv
// Directed bench: table of single-event vectors plus overflow, back-to-back,
// mid-record reset and drop-counter saturation sequences.
`timescale 1ns/1ps
module tb_trace_uart_streamer;
    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst, ot;
    logic [31:0] pc, wdata;
    logic [3:0]  wen;
    logic [4:0]  wnum;
    logic        uart_tx, fifo_full, busy;
    logic [15:0] drop_cnt;

    logic        s_rst, s_ot;
    logic [31:0] s_pc, s_wdata;
    logic [3:0]  s_wen;
    logic [4:0]  s_wnum;
    logic        s_tx, s_full, s_busy;
    logic [15:0] s_drop;
    bit          sat_done = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    logic [79:0] exp_rec [8];

    always #5 clk = ~clk;

    trace_uart_streamer #(.FIFO_DEPTH(4), .CLKS_PER_BIT(CPB)) u_dut (
        .clk(clk), .reset(rst), .open_trace(ot), .debug_wb_pc(pc),
        .debug_wb_rf_wen(wen), .debug_wb_rf_wnum(wnum), .debug_wb_rf_wdata(wdata),
        .uart_tx(uart_tx), .fifo_full(fifo_full), .drop_cnt(drop_cnt), .busy(busy));

    trace_uart_streamer #(.FIFO_DEPTH(4), .CLKS_PER_BIT(1024)) u_sat (
        .clk(clk), .reset(s_rst), .open_trace(s_ot), .debug_wb_pc(s_pc),
        .debug_wb_rf_wen(s_wen), .debug_wb_rf_wnum(s_wnum), .debug_wb_rf_wdata(s_wdata),
        .uart_tx(s_tx), .fifo_full(s_full), .drop_cnt(s_drop), .busy(s_busy));

    typedef struct {
        logic        ot;
        logic [3:0]  wen;
        logic [4:0]  wnum;
        logic [31:0] pc;
        logic [31:0] wdata;
        bit          exp_tx;
        logic [79:0] exp_rec;
    } vec_t;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic set_inputs(input logic o, input logic [3:0] w, input logic [4:0] n,
                              input logic [31:0] p, input logic [31:0] d);
        ot = o; wen = w; wnum = n; pc = p; wdata = d;
    endtask

    // One event cycle then back to quiet; returns 1ns into the cycle after the event.
    task automatic drive_event(input logic o, input logic [3:0] w, input logic [4:0] n,
                               input logic [31:0] p, input logic [31:0] d);
        @(posedge clk); #1 set_inputs(o, w, n, p, d);
        @(posedge clk); #1 set_inputs(1'b1, 4'd0, 5'd0, 32'd0, 32'd0);
    endtask

    task automatic wait_start(input int limit, output bit found);
        found = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (!uart_tx) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    // Called at the negedge of the first start-bit cycle; ends at the last stop-bit cycle.
    task automatic rx_from_start(output logic [79:0] rec, output int busy_cyc, output bit frame_ok);
        logic [7:0] cur;
        int bb;
        rec = '0; busy_cyc = 0; frame_ok = 1'b1; cur = 8'd0;
        for (int i = 0; i < 100 * CPB; i++) begin
            if (i > 0) @(negedge clk);
            if (busy) busy_cyc++;
            if (i % CPB == CPB / 2) begin
                bb = (i / CPB) % 10;
                if (bb == 0) begin
                    frame_ok &= (uart_tx == 1'b0);
                end else if (bb == 9) begin
                    frame_ok &= (uart_tx == 1'b1);
                    rec = {rec[71:0], cur};
                end else begin
                    cur[bb-1] = uart_tx;
                end
            end
        end
    endtask

    task automatic rx_burst(input int n);
        bit f;
        bit fo;
        int bc;
        logic [79:0] rec;
        wait_start(1000, f);
        check("burst_start_found", 80'(f), 80'd1);
        for (int k = 0; k < n; k++) begin
            rx_from_start(rec, bc, fo);
            check($sformatf("burst_rec%0d", k), rec, exp_rec[k]);
            check($sformatf("burst_busy_len%0d", k), 80'(bc), 80'd400);
            check($sformatf("burst_frame%0d", k), 80'(fo), 80'd1);
            @(negedge clk);
            check($sformatf("burst_idle%0d", k), 80'(uart_tx), 80'd1);
            if (k < n - 1) begin
                @(negedge clk);
                check($sformatf("burst_next_start%0d", k), 80'(uart_tx), 80'd0);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drop-counter saturation on a slow instance whose first record never finishes here.
    initial begin
        s_rst = 1'b1; s_ot = 1'b0; s_wen = 4'd0; s_wnum = 5'd0; s_pc = 32'd0; s_wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1 s_rst = 1'b0;
        @(posedge clk);
        #1 s_ot = 1'b1; s_wen = 4'h2; s_wnum = 5'd7; s_pc = 32'h0000_0100; s_wdata = 32'h5A5A_5A5A;
        for (int j = 0; j < 65550; j++) begin
            @(negedge clk);
            if (j == 4)     check("sat_not_full_j4", 80'(s_full), 80'd0);
            if (j == 5)     check("sat_full_j5", 80'(s_full), 80'd1);
            if (j == 5)     check("sat_drop_j5", 80'(s_drop), 80'd0);
            if (j == 105)   check("sat_drop_100", 80'(s_drop), 80'd100);
            if (j == 65539) check("sat_drop_65534", 80'(s_drop), 80'd65534);
            if (j == 65540) check("sat_drop_ffff", 80'(s_drop), 80'hFFFF);
            if (j == 65549) check("sat_drop_hold", 80'(s_drop), 80'hFFFF);
        end
        #1 s_wen = 4'd0;
        repeat (10) @(negedge clk);
        check("sat_drop_final", 80'(s_drop), 80'hFFFF);
        check("sat_full_final", 80'(s_full), 80'd1);
        sat_done = 1'b1;
    end

    initial begin
        vec_t tbl [6];
        logic [79:0] rec;
        int bc;
        bit fo, f;

        tbl[0] = '{1'b1, 4'hF, 5'd3,  32'hBFC0_0000, 32'h1234_5678, 1'b1, 80'hA5_BFC00000_03_12345678};
        tbl[1] = '{1'b1, 4'h0, 5'd3,  32'hBFC0_0000, 32'h1234_5678, 1'b0, 80'h0};
        tbl[2] = '{1'b1, 4'hF, 5'd0,  32'hBFC0_0000, 32'h1234_5678, 1'b0, 80'h0};
        tbl[3] = '{1'b0, 4'hF, 5'd3,  32'hBFC0_0000, 32'h1234_5678, 1'b0, 80'h0};
        tbl[4] = '{1'b1, 4'h1, 5'd31, 32'h8000_0004, 32'hDEAD_BEEF, 1'b1, 80'hA5_80000004_1F_DEADBEEF};
        tbl[5] = '{1'b1, 4'h8, 5'd1,  32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 80'hA5_FFFFFFFF_01_00000000};

        rst = 1'b1;
        set_inputs(1'b0, 4'd0, 5'd0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_tx", 80'(uart_tx), 80'd1);
        check("reset_full", 80'(fifo_full), 80'd0);
        check("reset_drop", 80'(drop_cnt), 80'd0);
        check("reset_busy", 80'(busy), 80'd0);

        for (int v = 0; v < 6; v++) begin
            drive_event(tbl[v].ot, tbl[v].wen, tbl[v].wnum, tbl[v].pc, tbl[v].wdata);
            if (tbl[v].exp_tx) begin
                @(negedge clk);
                check($sformatf("v%0d_lat_n1_tx", v), 80'(uart_tx), 80'd1);
                check($sformatf("v%0d_lat_n1_busy", v), 80'(busy), 80'd0);
                @(negedge clk);
                check($sformatf("v%0d_lat_n2_tx", v), 80'(uart_tx), 80'd0);
                rx_from_start(rec, bc, fo);
                check($sformatf("v%0d_record", v), rec, tbl[v].exp_rec);
                check($sformatf("v%0d_busy_len", v), 80'(bc), 80'd400);
                check($sformatf("v%0d_frame", v), 80'(fo), 80'd1);
                @(negedge clk);
                check($sformatf("v%0d_after_tx", v), 80'(uart_tx), 80'd1);
                check($sformatf("v%0d_after_busy", v), 80'(busy), 80'd0);
            end else begin
                wait_start(60, f);
                check($sformatf("v%0d_filter_quiet", v), 80'(f), 80'd0);
                check($sformatf("v%0d_filter_drop", v), 80'(drop_cnt), 80'd0);
                check($sformatf("v%0d_filter_busy", v), 80'(busy), 80'd0);
            end
        end

        // Overflow: 10 consecutive events into a depth-4 FIFO.
        exp_rec[0] = 80'hA5_10000000_01_C0DE0000;
        exp_rec[1] = 80'hA5_10000001_02_C0DE0001;
        exp_rec[2] = 80'hA5_10000002_03_C0DE0002;
        exp_rec[3] = 80'hA5_10000003_04_C0DE0003;
        exp_rec[4] = 80'hA5_10000004_05_C0DE0004;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    @(posedge clk);
                    #1 set_inputs(1'b1, 4'hF, 5'(i + 1), 32'h1000_0000 + 32'(i), 32'hC0DE_0000 + 32'(i));
                    @(negedge clk);
                    check($sformatf("ovf_full_c%0d", i), 80'(fifo_full), 80'(i >= 5));
                end
                @(posedge clk);
                #1 set_inputs(1'b1, 4'd0, 5'd0, 32'd0, 32'd0);
                repeat (393) @(negedge clk);
                check("ovf_full_before_pop", 80'(fifo_full), 80'd1);
                @(negedge clk);
                check("ovf_full_after_pop", 80'(fifo_full), 80'd0);
                check("ovf_drop", 80'(drop_cnt), 80'd5);
            end
            rx_burst(5);
        join
        wait_start(600, f);
        check("ovf_no_extra", 80'(f), 80'd0);

        // Back-to-back: three events one cycle apart.
        exp_rec[0] = 80'hA5_11111111_02_AAAA5555;
        exp_rec[1] = 80'hA5_22222222_04_0F0F0F0F;
        exp_rec[2] = 80'hA5_33333333_1F_00000001;
        fork
            begin
                drive_event(1'b1, 4'h3, 5'd2,  32'h1111_1111, 32'hAAAA_5555);
                drive_event(1'b1, 4'h4, 5'd4,  32'h2222_2222, 32'h0F0F_0F0F);
                drive_event(1'b1, 4'hC, 5'd31, 32'h3333_3333, 32'h0000_0001);
            end
            rx_burst(3);
        join
        check("b2b_drop", 80'(drop_cnt), 80'd5);

        // Reset during byte 4 with two records queued.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 set_inputs(1'b1, 4'hF, 5'(i + 9), 32'h7000_0000 + 32'(i), 32'h0000_1111);
        end
        @(posedge clk);
        #1 set_inputs(1'b1, 4'd0, 5'd0, 32'd0, 32'd0);
        repeat (165) @(posedge clk);
        @(negedge clk);
        check("rst_mid_busy_before", 80'(busy), 80'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_tx", 80'(uart_tx), 80'd1);
        check("rst_mid_busy", 80'(busy), 80'd0);
        check("rst_mid_full", 80'(fifo_full), 80'd0);
        check("rst_mid_drop", 80'(drop_cnt), 80'd0);
        wait_start(500, f);
        check("rst_mid_quiet", 80'(f), 80'd0);
        check("rst_mid_busy_quiet", 80'(busy), 80'd0);
        drive_event(1'b1, 4'h1, 5'd10, 32'h0000_0040, 32'hCAFE_F00D);
        @(negedge clk);
        @(negedge clk);
        check("rst_new_start", 80'(uart_tx), 80'd0);
        rx_from_start(rec, bc, fo);
        check("rst_new_record", rec, 80'hA5_00000040_0A_CAFEF00D);
        check("rst_new_busy_len", 80'(bc), 80'd400);

        for (int k = 0; k < 100000 && !sat_done; k++) @(posedge clk);
        check("sat_done", 80'(sat_done), 80'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
